// File: rtl/tpu_pkg.sv
// tpu_pkg: result-drain sizes, drain FSM state encoding and element sign extension.
package tpu_pkg;
    localparam int ADDRESSSIZE    = 10;
    localparam int MATRIX_SIZE    = 16;
    localparam int PARTIAL_SUM_BW = 24;
    localparam int OUT_BW         = 32;
    localparam int ELEM_W         = $clog2(MATRIX_SIZE);
    localparam int ROW_W          = MATRIX_SIZE * PARTIAL_SUM_BW;

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_SEND, ST_DONE} drain_state_e;

    function automatic logic [OUT_BW-1:0] sign_ext(input logic [PARTIAL_SUM_BW-1:0] x);
        return OUT_BW'($signed(x));
    endfunction
endpackage

// File: rtl/row_serializer.sv
// row_serializer: holds one result row and streams it out one sign-extended element per beat.
module row_serializer
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              active,
    input  logic              out_ready,
    input  logic [ROW_W-1:0]  rd_data,
    output logic              out_valid,
    output logic              elem_last,
    output logic              row_done,
    output logic [OUT_BW-1:0] out_data
);
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic              fire;

    always_comb begin
        fire      = active & out_ready;
        elem_last = elem_q == ELEM_W'(MATRIX_SIZE - 1);
        row_done  = fire & elem_last;
        out_valid = active;
        out_data  = active ? sign_ext(row_q[elem_q*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]) : '0;
        row_d     = load ? rd_data : row_q;
        elem_d    = (load || row_done) ? '0 : elem_q + ELEM_W'(fire);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q  <= '0;
            elem_q <= '0;
        end else begin
            row_q  <= row_d;
            elem_q <= elem_d;
        end
    end
endmodule

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl: reads finished result rows from SRAM and drains them as a beat stream,
// one row at a time with no prefetch; pulses done when the last row has been accepted.
module result_drain_ctrl
    import tpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   drain_start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    output logic                   sram_rd_en,
    output logic [ADDRESSSIZE-1:0] sram_addr,
    input  logic [ROW_W-1:0]       sram_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_BW-1:0]      out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    drain_state_e           state_q, state_d;
    logic [ADDRESSSIZE-1:0] base_q, base_d, rows_q, rows_d, row_idx_q, row_idx_d;
    logic                   elem_last, row_done, last_row;

    row_serializer u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load      (state_q == ST_WAIT),
        .active    (state_q == ST_SEND),
        .out_ready (out_ready),
        .rd_data   (sram_rd_data),
        .out_valid (out_valid),
        .elem_last (elem_last),
        .row_done  (row_done),
        .out_data  (out_data)
    );

    assign last_row   = row_idx_q == rows_q - ADDRESSSIZE'(1);
    assign sram_rd_en = state_q == ST_READ;
    assign sram_addr  = sram_rd_en ? base_q + row_idx_q : '0;
    assign out_last   = out_valid & elem_last & last_row;
    assign busy       = state_q inside {ST_READ, ST_WAIT, ST_SEND};
    assign done       = state_q == ST_DONE;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        rows_d    = rows_q;
        row_idx_d = row_idx_q;
        unique case (state_q)
            ST_IDLE: if (drain_start) begin
                base_d    = base_addr;
                rows_d    = num_rows;
                row_idx_d = '0;
                state_d   = num_rows != '0 ? ST_READ : ST_DONE;
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: if (row_done) begin
                state_d   = last_row ? ST_DONE : ST_READ;
                row_idx_d = last_row ? row_idx_q : row_idx_q + ADDRESSSIZE'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rows_q    <= rows_d;
            row_idx_q <= row_idx_d;
        end
    end
endmodule
